// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU fetch path: next-PC select codes,
// fetch FSM state encoding, reset PC and instruction-memory window size.
package cpu_pkg;

  // Next-PC select codes (npc_sel)
  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  // Fetch FSM states, binary encoded
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [32:0] IM_BYTES         = 33'd4096;

  // Branch offset: word offset sign-extended and scaled to bytes
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_npc_calc.sv
// Combinational next-PC generator: sequential, branch, jump and register-jump
// targets, plus a misalignment flag for register jumps.
module npc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_sel,
  input  logic [15:0] imm16,
  input  logic [25:0] jidx,
  input  logic [31:0] jr_target,
  output logic [31:0] npc,
  output logic [31:0] pc_plus4,
  output logic        misalign
);

  logic [31:0] pc_plus4_s;

  // Sequential address; wraps mod 2^32
  always_comb begin
    pc_plus4_s = pc + 32'd4;
  end

  assign pc_plus4 = pc_plus4_s;

  // Target selection; jr target has its low two bits forced to zero
  always_comb begin
    npc      = pc_plus4_s;
    misalign = 1'b0;
    case (npc_sel)
      NPC_SEQ: npc = pc_plus4_s;
      NPC_BR:  npc = pc_plus4_s + branch_offset(imm16);
      NPC_J:   npc = {pc_plus4_s[31:28], jidx, 2'b00};
      NPC_JR: begin
        npc      = {jr_target[31:2], 2'b00};
        misalign = (jr_target[1:0] != 2'b00);
      end
      default: npc = pc_plus4_s;
    endcase
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: holds the PC, drives the instruction-memory
// word address and captures the returned word into IR under a req/done
// handshake with the control FSM.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned MEM_LAT  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  output logic        fetch_done,
  output logic        busy,
  input  logic        pc_we,
  input  logic [1:0]  npc_sel,
  input  logic [15:0] imm16,
  input  logic [25:0] jidx,
  input  logic [31:0] jr_target,
  output logic [9:0]  im_addr,
  input  logic [31:0] im_dout,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ir,
  output logic        addr_err,
  output logic        oob
);

  localparam logic [2:0] LAT_C = 3'(MEM_LAT);

  fetch_state_e state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic         addr_err_q, addr_err_d;
  logic         fetch_done_q, fetch_done_d;
  logic         busy_q, busy_d;

  logic [31:0]  npc_s;
  logic         misalign_s;
  logic         pc_upd_s;

  npc_calc u_npc (
    .pc        (pc_q),
    .npc_sel   (npc_sel),
    .imm16     (imm16),
    .jidx      (jidx),
    .jr_target (jr_target),
    .npc       (npc_s),
    .pc_plus4  (pc_plus4),
    .misalign  (misalign_s)
  );

  // Fetch FSM: wait MEM_LAT extra cycles, capture IR, pulse done for one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          state_d = ST_WAIT;
          cnt_d   = LAT_C;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          ir_d    = im_dout;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q - 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d       = (state_d == ST_WAIT);
    fetch_done_d = (state_d == ST_DONE);
  end

  // PC update is blocked in WAIT so the memory address stays stable
  always_comb begin
    pc_upd_s = pc_we && (state_q != ST_WAIT);
    if (pc_upd_s) begin
      pc_d       = npc_s;
      addr_err_d = addr_err_q | misalign_s;
    end else begin
      pc_d       = pc_q;
      addr_err_d = addr_err_q;
    end
  end

  // State, counter, PC, IR and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      pc_q         <= RESET_PC;
      ir_q         <= 32'd0;
      addr_err_q   <= 1'b0;
      fetch_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      addr_err_q   <= addr_err_d;
      fetch_done_q <= fetch_done_d;
      busy_q       <= busy_d;
    end
  end

  assign pc         = pc_q;
  assign ir         = ir_q;
  assign im_addr    = pc_q[11:2];
  assign busy       = busy_q;
  assign fetch_done = fetch_done_q;
  assign addr_err   = addr_err_q;
  // Window flag only; the memory address still wraps inside 4 KB
  assign oob = (pc_q < RESET_PC) || ({1'b0, pc_q} >= ({1'b0, RESET_PC} + IM_BYTES));

endmodule
